// File: rtl/bp_me_wormhole_lce_req_flit_tx_if.sv
// bp_me_wormhole_lce_req_flit_tx_if: packet-in / flit-out handshake bundle for the LCE request flit serializer
//   packet_i/packet_v_i/packet_ready_o : encoded packet input handshake
//   link_data_o/link_v_o/link_ready_i  : coh NoC flit link handshake
//   len_err_o                          : sticky oversize-len flag
interface bp_me_wormhole_lce_req_flit_tx_if #(
    parameter int flit_width_p = 64,
    parameter int pkt_width_p  = 256
);
    logic [pkt_width_p-1:0]  packet_i;
    logic                    packet_v_i;
    logic                    packet_ready_o;
    logic [flit_width_p-1:0] link_data_o;
    logic                    link_v_o;
    logic                    link_ready_i;
    logic                    len_err_o;
    modport master (
        output packet_i, packet_v_i, link_ready_i,
        input  packet_ready_o, link_data_o, link_v_o, len_err_o
    );
    modport slave (
        input  packet_i, packet_v_i, link_ready_i,
        output packet_ready_o, link_data_o, link_v_o, len_err_o
    );
endinterface

// File: rtl/bp_me_wormhole_lce_req_flit_tx.sv
// bp_me_wormhole_lce_req_flit_tx: serializes one encoded LCE request packet into len+1 LSB-first NoC flits
//   clk_i, reset_i : clock, synchronous active-high reset
//   io (slave)     : packet input handshake, flit link handshake, sticky len_err_o
module bp_me_wormhole_lce_req_flit_tx #(
    parameter int flit_width_p = 64,
    parameter int len_width_p  = 4,
    parameter int cord_width_p = 8,
    parameter int pkt_width_p  = 256
) (
    input logic clk_i,
    input logic reset_i,
    bp_me_wormhole_lce_req_flit_tx_if.slave io
);
    localparam int max_flits_lp = (pkt_width_p + flit_width_p - 1) / flit_width_p;
    localparam int cnt_width_lp = max_flits_lp > 1 ? $clog2(max_flits_lp) : 1;
    localparam int pad_w_lp = max_flits_lp * flit_width_p;
    localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_flits_lp - 1);
    typedef enum logic {IDLE, SEND} state_e;
    state_e                                  r_state;
    logic                                    r_link_v;
    logic                                    r_len_err;
    logic [pkt_width_p-1:0]                  r_pkt;
    logic [cnt_width_lp-1:0]                 r_cnt;
    logic [cnt_width_lp-1:0]                 r_eff_len;
    logic [max_flits_lp-1:0][flit_width_p-1:0] w_flits;
    logic [len_width_p-1:0]                  w_len;
    logic                                    w_len_err;
    logic [cnt_width_lp-1:0]                 w_eff_len;
    logic                                    w_last;
    logic                                    w_accept;
    logic                                    w_link_hs;
    // zero-extending the packet pads the final flit with zeros
    assign w_flits   = pad_w_lp'(r_pkt);
    assign w_len     = io.packet_i[cord_width_p +: len_width_p];
    assign w_len_err = w_len > max_len_lp;
    assign w_eff_len = w_len_err ? cnt_width_lp'(max_flits_lp - 1) : cnt_width_lp'(w_len);
    assign w_last    = r_cnt == r_eff_len;
    assign w_link_hs = r_link_v & io.link_ready_i;
    // ready also on the last-flit handshake so back-to-back packets need no bubble
    assign io.packet_ready_o = !reset_i & ((r_state == IDLE) | ((r_state == SEND) & w_last & io.link_ready_i));
    assign w_accept    = io.packet_v_i & io.packet_ready_o;
    assign io.link_v_o    = r_link_v;
    assign io.link_data_o = w_flits[r_cnt];
    assign io.len_err_o   = r_len_err;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_link_v  <= 1'b0;
            r_len_err <= 1'b0;
            r_pkt     <= '0;
            r_cnt     <= '0;
            r_eff_len <= '0;
        end else if (w_accept) begin
            r_state   <= SEND;
            r_link_v  <= 1'b1;
            r_len_err <= r_len_err | w_len_err;
            r_pkt     <= io.packet_i;
            r_cnt     <= '0;
            r_eff_len <= w_eff_len;
        end else if (w_link_hs) begin
            r_state  <= w_last ? IDLE : SEND;
            r_link_v <= !w_last;
            r_cnt    <= w_last ? r_cnt : r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_bp_me_wormhole_lce_req_flit_tx.sv
// tb_bp_me_wormhole_lce_req_flit_tx: directed self-checking bench for the LCE request flit serializer
module tb_bp_me_wormhole_lce_req_flit_tx;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   pass_cnt = 0;
    int   total = 0;
    always #5 clk = ~clk;
    bp_me_wormhole_lce_req_flit_tx_if #(.flit_width_p(64), .pkt_width_p(150)) bus ();
    bp_me_wormhole_lce_req_flit_tx #(
        .flit_width_p(64), .len_width_p(4), .cord_width_p(8), .pkt_width_p(150)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .io(bus.slave)
    );
    function automatic logic [149:0] mk(input logic [63:0] a, input logic [63:0] b,
                                        input logic [21:0] c, input logic [3:0] len);
        logic [149:0] p;
        p = {c, b, a};
        p[11:8] = len;
        return p;
    endfunction
    function automatic logic [63:0] flit(input logic [149:0] p, input int k);
        return k == 0 ? p[63:0] : k == 1 ? p[127:64] : {42'b0, p[149:128]};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        bus.packet_i = '0;
        bus.packet_v_i = 1'b0;
        bus.link_ready_i = 1'b1;
        reset_i = 1'b1;
        tick();
        tick();
        #1;
        total++;
        if (bus.link_v_o !== 1'b0) $display("FAIL reset_link_v got=%b exp=0", bus.link_v_o); else pass_cnt++;
        total++;
        if (bus.packet_ready_o !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.packet_ready_o); else pass_cnt++;
        total++;
        if (bus.len_err_o !== 1'b0) $display("FAIL reset_len_err got=%b exp=0", bus.len_err_o); else pass_cnt++;
        reset_i = 1'b0;
        tick();
        #1;
        total++;
        if (bus.packet_ready_o !== 1'b1) $display("FAIL idle_ready got=%b exp=1", bus.packet_ready_o); else pass_cnt++;
    endtask
    task automatic test_single();
        logic [149:0] p;
        p = mk(64'h0123_4567_89ab_cdef, 64'hdead_beef_cafe_f00d, 22'h155aa5, 4'd0);
        bus.packet_i = p;
        bus.packet_v_i = 1'b1;
        bus.link_ready_i = 1'b1;
        #1;
        total++;
        if (bus.packet_ready_o !== 1'b1 || bus.link_v_o !== 1'b0)
            $display("FAIL single_idle got=rdy%b v%b exp=rdy1 v0", bus.packet_ready_o, bus.link_v_o); else pass_cnt++;
        tick();
        bus.packet_v_i = 1'b0;
        #1;
        total++;
        if (bus.link_v_o !== 1'b1 || bus.link_data_o !== p[63:0])
            $display("FAIL single_flit0 got=v%b %h exp=v1 %h", bus.link_v_o, bus.link_data_o, p[63:0]); else pass_cnt++;
        tick();
        #1;
        total++;
        if (bus.link_v_o !== 1'b0 || bus.packet_ready_o !== 1'b1)
            $display("FAIL single_done got=v%b rdy%b exp=v0 rdy1", bus.link_v_o, bus.packet_ready_o); else pass_cnt++;
    endtask
    task automatic test_len2();
        logic [149:0] p;
        p = mk(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 22'h3abcde, 4'd2);
        bus.packet_i = p;
        bus.packet_v_i = 1'b1;
        bus.link_ready_i = 1'b1;
        tick();
        bus.packet_v_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (bus.link_v_o !== 1'b1 || bus.link_data_o !== flit(p, k))
                $display("FAIL len2_flit%0d got=v%b %h exp=v1 %h", k, bus.link_v_o, bus.link_data_o, flit(p, k)); else pass_cnt++;
            tick();
        end
        #1;
        total++;
        if (bus.link_v_o !== 1'b0) $display("FAIL len2_end got=v%b exp=v0", bus.link_v_o); else pass_cnt++;
    endtask
    task automatic test_backpressure();
        logic [149:0] p;
        logic [5:0]   pat;
        int           k;
        p = mk(64'hfeed_face_0bad_f00d, 64'h0f0f_0f0f_f0f0_f0f0, 22'h2c3c4c, 4'd2);
        pat = 6'b101001;
        k = 0;
        bus.packet_i = p;
        bus.packet_v_i = 1'b1;
        bus.link_ready_i = 1'b0;
        tick();
        bus.packet_v_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.link_ready_i = pat[i];
            #1;
            total++;
            if (bus.link_v_o !== 1'b1 || bus.link_data_o !== flit(p, k))
                $display("FAIL bp_cyc%0d got=v%b %h exp=v1 %h", i, bus.link_v_o, bus.link_data_o, flit(p, k)); else pass_cnt++;
            total++;
            if (bus.packet_ready_o !== (k == 2 && pat[i]))
                $display("FAIL bp_ready%0d got=%b exp=%b", i, bus.packet_ready_o, (k == 2 && pat[i])); else pass_cnt++;
            if (pat[i]) k++;
            tick();
        end
        #1;
        total++;
        if (bus.link_v_o !== 1'b0) $display("FAIL bp_end got=v%b exp=v0", bus.link_v_o); else pass_cnt++;
        bus.link_ready_i = 1'b1;
    endtask
    task automatic test_back_to_back();
        logic [149:0] a, b;
        a = mk(64'haaaa_0000_aaaa_0001, 64'haaaa_1111_aaaa_1112, 22'h0aaaaa, 4'd1);
        b = mk(64'hbbbb_0000_bbbb_0001, 64'hbbbb_1111_bbbb_1112, 22'h1bbbbb, 4'd0);
        bus.link_ready_i = 1'b1;
        bus.packet_i = a;
        bus.packet_v_i = 1'b1;
        tick();
        bus.packet_i = b;
        #1;
        total++;
        if (bus.link_data_o !== a[63:0] || bus.packet_ready_o !== 1'b0)
            $display("FAIL b2b_a0 got=%h rdy%b exp=%h rdy0", bus.link_data_o, bus.packet_ready_o, a[63:0]); else pass_cnt++;
        tick();
        #1;
        total++;
        if (bus.link_data_o !== a[127:64] || bus.packet_ready_o !== 1'b1 || bus.link_v_o !== 1'b1)
            $display("FAIL b2b_a1 got=%h rdy%b v%b exp=%h rdy1 v1", bus.link_data_o, bus.packet_ready_o, bus.link_v_o, a[127:64]); else pass_cnt++;
        tick();
        bus.packet_v_i = 1'b0;
        #1;
        total++;
        if (bus.link_v_o !== 1'b1 || bus.link_data_o !== b[63:0])
            $display("FAIL b2b_b0 got=v%b %h exp=v1 %h", bus.link_v_o, bus.link_data_o, b[63:0]); else pass_cnt++;
        tick();
        #1;
        total++;
        if (bus.link_v_o !== 1'b0) $display("FAIL b2b_end got=v%b exp=v0", bus.link_v_o); else pass_cnt++;
    endtask
    task automatic test_len_err();
        logic [149:0] p;
        p = mk(64'h7777_7777_1234_5678, 64'h8888_8888_9abc_def0, 22'h123456, 4'd7);
        bus.link_ready_i = 1'b1;
        #1;
        total++;
        if (bus.len_err_o !== 1'b0) $display("FAIL lenerr_pre got=%b exp=0", bus.len_err_o); else pass_cnt++;
        bus.packet_i = p;
        bus.packet_v_i = 1'b1;
        tick();
        bus.packet_v_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (bus.len_err_o !== 1'b1 || bus.link_v_o !== 1'b1 || bus.link_data_o !== flit(p, k))
                $display("FAIL lenerr_flit%0d got=e%b v%b %h exp=e1 v1 %h", k, bus.len_err_o, bus.link_v_o, bus.link_data_o, flit(p, k)); else pass_cnt++;
            tick();
        end
        #1;
        total++;
        if (bus.link_v_o !== 1'b0 || bus.len_err_o !== 1'b1)
            $display("FAIL lenerr_end got=v%b e%b exp=v0 e1", bus.link_v_o, bus.len_err_o); else pass_cnt++;
    endtask
    task automatic test_reset_mid();
        logic [149:0] p, q;
        p = mk(64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202, 22'h030303, 4'd2);
        q = mk(64'h9999_aaaa_bbbb_cccc, 64'hdddd_eeee_ffff_0000, 22'h2468ac, 4'd2);
        bus.link_ready_i = 1'b1;
        bus.packet_i = p;
        bus.packet_v_i = 1'b1;
        tick();
        bus.packet_v_i = 1'b0;
        #1;
        total++;
        if (bus.link_data_o !== p[63:0]) $display("FAIL rst_flit0 got=%h exp=%h", bus.link_data_o, p[63:0]); else pass_cnt++;
        tick();
        reset_i = 1'b1;
        #1;
        total++;
        if (bus.packet_ready_o !== 1'b0) $display("FAIL rst_ready got=%b exp=0", bus.packet_ready_o); else pass_cnt++;
        tick();
        reset_i = 1'b0;
        #1;
        total++;
        if (bus.link_v_o !== 1'b0 || bus.len_err_o !== 1'b0 || bus.packet_ready_o !== 1'b1)
            $display("FAIL rst_after got=v%b e%b rdy%b exp=v0 e0 rdy1", bus.link_v_o, bus.len_err_o, bus.packet_ready_o); else pass_cnt++;
        bus.packet_i = q;
        bus.packet_v_i = 1'b1;
        tick();
        bus.packet_v_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (bus.link_v_o !== 1'b1 || bus.link_data_o !== flit(q, k))
                $display("FAIL rst_new_flit%0d got=v%b %h exp=v1 %h", k, bus.link_v_o, bus.link_data_o, flit(q, k)); else pass_cnt++;
            tick();
        end
        #1;
        total++;
        if (bus.link_v_o !== 1'b0) $display("FAIL rst_new_end got=v%b exp=v0", bus.link_v_o); else pass_cnt++;
    endtask
    initial begin
        test_reset();
        test_single();
        test_len2();
        test_backpressure();
        test_back_to_back();
        test_len_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
